// File: rtl/agc_wb_sequencer_if.sv
// Wishbone bus bundle between agc_wb_sequencer (master) and the AGC register target (slave).
// 8-bit byte address, 32-bit data, classic single-transfer handshake.
`timescale 1ns/1ps
interface agc_wb_sequencer_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [7:0]  adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/agc_wb_sequencer.sv
// Wishbone initiator running one AGC measurement cycle (program, tick, poll, read back).
// Optional poll timeout is built when AGC_SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module agc_wb_sequencer #(
  parameter logic [7:0] BASE_ADDR     = 8'h00,
  parameter int         POLL_WAIT     = 64,
  parameter int         TIMEOUT_POLLS = 4096
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  agc_wb_sequencer_if.master wb,
  input  logic               start_i,
  input  logic               load_i,
  input  logic [16:0]        scale_i,
  input  logic [15:0]        offset_i,
  output logic               busy_o,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [24:0]        sq_o,
  output logic [20:0]        gt_o,
  output logic [20:0]        lt_o,
  output logic               err_o
);
  localparam int WAIT_W = $clog2(POLL_WAIT + 1);

  typedef enum logic [3:0] {
    IDLE, WR_SCALE, WR_OFFSET, WR_LOAD, WR_APPLY, WR_TICK,
    WAIT, POLL, RD_SQ, RD_GT, RD_LT, RESULT
  } state_t;

  state_t              state_q, state_d;
  logic                cyc_q, we_q, err_q;
  logic [7:0]          adr_q;
  logic [31:0]         dat_q;
  logic [3:0]          sel_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [16:0]         scale_q;
  logic [15:0]         offset_q;
  logic [24:0]         sq_q;
  logic [20:0]         gt_q, lt_q;

  logic                bus_state, req_we, ok, bus_err, resp, err_d, timeout_hit;
  logic [7:0]          req_off;
  logic [31:0]         req_dat;
  logic [3:0]          req_sel;
  logic                unused_dat_hi;

  assign unused_dat_hi = ^wb.dat_r[31:25];

`ifdef AGC_SEQ_TIMEOUT_EN
  logic [12:0] poll_cnt_q;
  assign timeout_hit = (state_q == POLL) && ok && !wb.dat_r[1] &&
                       (poll_cnt_q == 13'(TIMEOUT_POLLS - 1));
`else
  localparam int unused_timeout_polls = TIMEOUT_POLLS;
  assign timeout_hit = 1'b0;
`endif

  // err outranks ack when both are sampled; rty alone just reissues
  assign resp    = cyc_q & (wb.ack | wb.err | wb.rty);
  assign ok      = cyc_q & wb.ack & ~wb.err;
  assign bus_err = cyc_q & wb.err;

  always_comb begin
    state_d   = state_q;
    bus_state = 1'b0;
    req_we    = 1'b0;
    req_off   = 8'h00;
    req_dat   = 32'h0;
    req_sel   = 4'hF;
    err_d     = 1'b0;
    case (state_q)
      IDLE:      if (start_i) state_d = load_i ? WR_SCALE : WR_TICK;
      WR_SCALE:  begin
        bus_state = 1'b1; req_we = 1'b1; req_off = 8'h10; req_sel = 4'b0111;
        req_dat = {15'b0, scale_q};
        if (ok) state_d = WR_OFFSET;
      end
      WR_OFFSET: begin
        bus_state = 1'b1; req_we = 1'b1; req_off = 8'h14; req_sel = 4'b0011;
        req_dat = {16'b0, offset_q};
        if (ok) state_d = WR_LOAD;
      end
      WR_LOAD:   begin
        bus_state = 1'b1; req_we = 1'b1; req_sel = 4'b0010; req_dat = 32'h300;
        if (ok) state_d = WR_APPLY;
      end
      WR_APPLY:  begin
        bus_state = 1'b1; req_we = 1'b1; req_sel = 4'b0010; req_dat = 32'h400;
        if (ok) state_d = WR_TICK;
      end
      WR_TICK:   begin
        bus_state = 1'b1; req_we = 1'b1; req_sel = 4'b0001; req_dat = 32'h1;
        if (ok) state_d = WAIT;
      end
      WAIT:      if (wait_cnt_q == WAIT_W'(POLL_WAIT - 1)) state_d = POLL;
      POLL:      begin
        bus_state = 1'b1;
        if (ok) state_d = wb.dat_r[1] ? RD_SQ : (timeout_hit ? IDLE : WAIT);
      end
      RD_SQ:     begin bus_state = 1'b1; req_off = 8'h04; if (ok) state_d = RD_GT; end
      RD_GT:     begin bus_state = 1'b1; req_off = 8'h08; if (ok) state_d = RD_LT; end
      RD_LT:     begin bus_state = 1'b1; req_off = 8'h0C; if (ok) state_d = RESULT; end
      RESULT:    if (res_ready_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (bus_err) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
    if (timeout_hit) err_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= 8'h00;
      dat_q      <= 32'h0;
      sel_q      <= 4'h0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
      scale_q    <= '0;
      offset_q   <= '0;
      sq_q       <= '0;
      gt_q       <= '0;
      lt_q       <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      // a bus state launches only from an idle bus, so every transfer is preceded by a gap cycle
      if (cyc_q) begin
        if (resp) cyc_q <= 1'b0;
      end else if (bus_state) begin
        cyc_q <= 1'b1;
        we_q  <= req_we;
        adr_q <= BASE_ADDR | req_off;
        dat_q <= req_dat;
        sel_q <= req_sel;
      end
      wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + 1'b1 : '0;
      if (state_q == IDLE && start_i) begin
        scale_q  <= scale_i;
        offset_q <= offset_i;
      end
      if (ok && state_q == RD_SQ) sq_q <= wb.dat_r[24:0];
      if (ok && state_q == RD_GT) gt_q <= wb.dat_r[20:0];
      if (ok && state_q == RD_LT) lt_q <= wb.dat_r[20:0];
    end
  end

`ifdef AGC_SEQ_TIMEOUT_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                   poll_cnt_q <= '0;
    else if (state_q == WR_TICK)    poll_cnt_q <= '0;
    else if (state_q == POLL && ok) poll_cnt_q <= poll_cnt_q + 1'b1;
  end
`endif

  assign wb.cyc      = cyc_q;
  assign wb.stb      = cyc_q;
  assign wb.we       = we_q;
  assign wb.adr      = adr_q;
  assign wb.dat_w    = dat_q;
  assign wb.sel      = sel_q;
  assign busy_o      = (state_q != IDLE) && (state_q != RESULT);
  assign res_valid_o = (state_q == RESULT);
  assign sq_o        = sq_q;
  assign gt_o        = gt_q;
  assign lt_o        = lt_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_agc_wb_sequencer.sv
// Bench for agc_wb_sequencer: behavioural register target plus transaction/result scoreboards.
`timescale 1ns/1ps
module tb_agc_wb_sequencer;
  localparam int POLL_WAIT     = 4;
  localparam int TIMEOUT_POLLS = 4;

  typedef struct packed {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } txn_t;

  typedef struct packed {
    logic [24:0] sq;
    logic [20:0] gt;
    logic [20:0] lt;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, load_i = 1'b0, res_ready_i = 1'b0;
  logic [16:0] scale_i = '0;
  logic [15:0] offset_i = '0;
  logic        busy_o, res_valid_o, err_o;
  logic [24:0] sq_o;
  logic [20:0] gt_o, lt_o;

  logic        m_ack = 1'b0, m_err = 1'b0, m_rty = 1'b0;
  logic [31:0] m_dat = '0;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  txn_t exp_q[$];
  res_t res_q[$];
  int   poll_times[$];

  int          idle_run = 100;
  int          polls_seen = 0;
  int          done_after = 1;
  bit          rty_tick_once = 0, err_on_gt = 0, expect_reissue = 0;
  logic [24:0] m_sq = '0;
  logic [20:0] m_gt = '0, m_lt = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  agc_wb_sequencer_if wb ();
  assign wb.ack   = m_ack;
  assign wb.err   = m_err;
  assign wb.rty   = m_rty;
  assign wb.dat_r = m_dat;

  agc_wb_sequencer #(
    .BASE_ADDR     (8'h00),
    .POLL_WAIT     (POLL_WAIT),
    .TIMEOUT_POLLS (TIMEOUT_POLLS)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb          (wb),
    .start_i     (start_i),
    .load_i      (load_i),
    .scale_i     (scale_i),
    .offset_i    (offset_i),
    .busy_o      (busy_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .sq_o        (sq_o),
    .gt_o        (gt_o),
    .lt_o        (lt_o),
    .err_o       (err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register target: answers each new strobe on the falling edge, sampled by the DUT on the next rise.
  always @(negedge clk) begin
    txn_t t;
    m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0; m_dat = '0;
    if (wb.cyc && wb.stb) begin
      check("bus_gap", 64'(idle_run >= 1), 64'd1);
      if (expect_reissue) begin
        check("rty_gap", 64'(idle_run), 64'd1);
        expect_reissue = 0;
      end
      idle_run = 0;
      if (exp_q.size() == 0) check("txn_unexpected", 64'd0, 64'd1);
      else begin
        t = exp_q.pop_front();
        check("txn", 64'({wb.we, wb.adr, wb.dat_w, wb.sel}), 64'(t));
      end
      if (wb.we && wb.adr == 8'h00 && wb.dat_w[0]) begin
        if (rty_tick_once) begin
          m_rty = 1'b1; rty_tick_once = 0; expect_reissue = 1;
        end else begin
          polls_seen = 0; m_ack = 1'b1;
        end
      end else if (!wb.we && wb.adr[4:2] == 3'd2 && err_on_gt) begin
        m_err = 1'b1; err_on_gt = 0;
      end else begin
        m_ack = 1'b1;
        if (!wb.we) begin
          case (wb.adr[4:2])
            3'd0: begin
              polls_seen++;
              poll_times.push_back(cyc_cnt);
              m_dat = (polls_seen >= done_after) ? 32'h0000_0002 : 32'hFFFF_FFFD;
            end
            3'd1:    m_dat = {7'h55, m_sq};
            3'd2:    m_dat = {11'h5A5, m_gt};
            3'd3:    m_dat = {11'h3C3, m_lt};
            default: m_dat = 32'h0;
          endcase
        end
      end
    end else idle_run++;
  end

  function automatic txn_t mk(input logic we, input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] s);
    return {we, a, d, s};
  endfunction

  task automatic push_run(input logic ld, input logic [16:0] sc, input logic [15:0] of,
                          input int polls, input int reads);
    if (ld) begin
      exp_q.push_back(mk(1'b1, 8'h10, {15'b0, sc}, 4'b0111));
      exp_q.push_back(mk(1'b1, 8'h14, {16'b0, of}, 4'b0011));
      exp_q.push_back(mk(1'b1, 8'h00, 32'h300, 4'b0010));
      exp_q.push_back(mk(1'b1, 8'h00, 32'h400, 4'b0010));
    end
    exp_q.push_back(mk(1'b1, 8'h00, 32'h1, 4'b0001));
    for (int i = 0; i < polls; i++) exp_q.push_back(mk(1'b0, 8'h00, 32'h0, 4'hF));
    if (reads > 0) exp_q.push_back(mk(1'b0, 8'h04, 32'h0, 4'hF));
    if (reads > 1) exp_q.push_back(mk(1'b0, 8'h08, 32'h0, 4'hF));
    if (reads > 2) exp_q.push_back(mk(1'b0, 8'h0C, 32'h0, 4'hF));
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic ld, input logic [16:0] sc, input logic [15:0] of);
    start_i = 1'b1; load_i = ld; scale_i = sc; offset_i = of;
    tick_n(1);
    start_i = 1'b0; load_i = 1'b0; scale_i = '0; offset_i = '0;
    check("busy_after_start", 64'(busy_o), 64'd1);
  endtask

  task automatic wait_result(input string tag);
    res_t r;
    int n = 0;
    while (!res_valid_o && n < 2000) begin tick_n(1); n++; end
    check({tag, "_valid"}, 64'(res_valid_o), 64'd1);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    r = (res_q.size() != 0) ? res_q.pop_front() : '0;
    check({tag, "_sq"}, 64'(sq_o), 64'(r.sq));
    check({tag, "_gt"}, 64'(gt_o), 64'(r.gt));
    check({tag, "_lt"}, 64'(lt_o), 64'(r.lt));
  endtask

  task automatic accept(input string tag);
    res_ready_i = 1'b1;
    tick_n(1);
    res_ready_i = 1'b0;
    check({tag, "_released"}, 64'(res_valid_o), 64'd0);
    check({tag, "_expq_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_err(input string tag);
    int err_cycles = 0;
    int valid_seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (err_o) err_cycles++;
      if (res_valid_o) valid_seen++;
      tick_n(1);
    end
    check({tag, "_err_pulse"}, 64'(err_cycles), 64'd1);
    check({tag, "_no_result"}, 64'(valid_seen), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_expq_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    tick_n(3);
    check("rst_cyc", 64'(wb.cyc), 64'd0);
    check("rst_stb", 64'(wb.stb), 64'd0);
    check("rst_bus", 64'({wb.we, wb.adr, wb.dat_w, wb.sel}), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_valid", 64'(res_valid_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_res", 64'({sq_o, gt_o, lt_o}), 64'd0);
    rst = 1'b0;
    tick_n(2);

    // programmed run
    done_after = 1; m_sq = 25'h0123456; m_gt = 21'h00777; m_lt = 21'h1F00F;
    push_run(1'b1, 17'h1ABCD, 16'h0180, 1, 3);
    r = {m_sq, m_gt, m_lt}; res_q.push_back(r);
    start_seq(1'b1, 17'h1ABCD, 16'h0180);
    wait_result("load_run");
    accept("load_run");

    // tick only, done after three polls, result held against backpressure
    tick_n(2);
    done_after = 3; m_sq = 25'h1FFFFFF; m_gt = 21'h12345; m_lt = 21'h0ABCD;
    poll_times.delete();
    push_run(1'b0, '0, '0, 3, 3);
    r = {m_sq, m_gt, m_lt}; res_q.push_back(r);
    start_seq(1'b0, 17'h1FFFF, 16'hFFFF);
    wait_result("poll_run");
    check("poll_count", 64'(poll_times.size()), 64'd3);
    if (poll_times.size() == 3) begin
      check("poll_space1", 64'(poll_times[1] - poll_times[0]), 64'(POLL_WAIT + 2));
      check("poll_space2", 64'(poll_times[2] - poll_times[1]), 64'(POLL_WAIT + 2));
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(res_valid_o), 64'd1);
      check("hold_data", 64'({sq_o, gt_o, lt_o}), 64'(r));
      tick_n(1);
    end
    start_i = 1'b1;
    accept("poll_run");
    start_i = 1'b0;
    tick_n(3);
    check("start_in_result_ignored", 64'(busy_o), 64'd0);

    // retry on the tick write
    done_after = 1; rty_tick_once = 1; m_sq = 25'h0AAAAAA; m_gt = 21'h15555; m_lt = 21'h0F0F0;
    exp_q.push_back(mk(1'b1, 8'h00, 32'h1, 4'b0001));
    push_run(1'b0, '0, '0, 1, 3);
    r = {m_sq, m_gt, m_lt}; res_q.push_back(r);
    start_seq(1'b0, '0, '0);
    wait_result("rty_run");
    check("rty_reissued", 64'(expect_reissue), 64'd0);
    accept("rty_run");

    // bus error while reading gt
    tick_n(1);
    done_after = 1; err_on_gt = 1;
    push_run(1'b0, '0, '0, 1, 2);
    start_seq(1'b0, '0, '0);
    wait_err("err_run");
    m_sq = 25'h1000001; m_gt = 21'h00001; m_lt = 21'h10000;
    push_run(1'b1, 17'h00005, 16'h8001, 1, 3);
    r = {m_sq, m_gt, m_lt}; res_q.push_back(r);
    start_seq(1'b1, 17'h00005, 16'h8001);
    wait_result("after_err");
    accept("after_err");

    // asynchronous reset while waiting between polls
    tick_n(1);
    done_after = 3;
    exp_q.push_back(mk(1'b1, 8'h00, 32'h1, 4'b0001));
    start_seq(1'b0, '0, '0);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick_n(1);
    tick_n(1);
    check("pre_rst_busy", 64'(busy_o), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_cyc", 64'(wb.cyc), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_res", 64'({sq_o, gt_o, lt_o}), 64'd0);
    check("arst_bus", 64'({wb.we, wb.adr, wb.dat_w, wb.sel}), 64'd0);
    tick_n(2);
    rst = 1'b0;
    check("arst_expq_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    tick_n(1);
    done_after = 2; m_sq = 25'h0000ABC; m_gt = 21'h1FFFFF; m_lt = 21'h00000;
    push_run(1'b1, 17'h10001, 16'h0100, 2, 3);
    r = {m_sq, m_gt, m_lt}; res_q.push_back(r);
    start_seq(1'b1, 17'h10001, 16'h0100);
    wait_result("after_rst");
    accept("after_rst");

`ifdef AGC_SEQ_TIMEOUT_EN
    // done never reported: abort after TIMEOUT_POLLS reads
    tick_n(1);
    done_after = 1000;
    poll_times.delete();
    push_run(1'b0, '0, '0, TIMEOUT_POLLS, 0);
    start_seq(1'b0, '0, '0);
    wait_err("timeout");
    check("timeout_polls", 64'(poll_times.size()), 64'(TIMEOUT_POLLS));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
